// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring radix-2 integer divider.
// Signed or unsigned per operation, divide-by-zero reporting,
// valid/ready handshakes on both the operand and the result side.
module seq_divider #(
    parameter int N         = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         signed_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy
);
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_DIVIDE, S_FIXUP, S_ZERO, S_DONE
    } state_t;

    state_t r_state, w_next;

    // captured operands
    logic [N-1:0]  r_a, r_b;
    logic          r_sm;
    // working datapath
    logic [N-1:0]  r_rem;      // partial remainder
    logic [N-1:0]  r_dvd;      // dividend shifting out, quotient shifting in
    logic [N-1:0]  r_dsr;      // |b|
    logic          r_sign_q, r_sign_r;
    logic [CW-1:0] r_cnt;
    // result registers
    logic [N-1:0]  r_quot, r_remo;
    logic          r_dbz, r_ovalid;

    logic          w_accept, w_xfer, w_sm_in;
    logic          w_sa, w_sb;
    logic [N-1:0]  w_mag_a, w_mag_b;
    logic [N:0]    w_shift;
    logic          w_ge;
    logic [N-1:0]  w_diff;

    assign w_accept = in_valid & in_ready;
    assign w_xfer   = r_ovalid & out_ready;
    assign w_sm_in  = (SIGNED_EN != 0) & signed_mode;

    // Operand signs only matter in signed mode; the most negative value
    // negates to itself, which is the correct unsigned magnitude.
    assign w_sa    = r_sm & r_a[N-1];
    assign w_sb    = r_sm & r_b[N-1];
    assign w_mag_a = w_sa ? -r_a : r_a;
    assign w_mag_b = w_sb ? -r_b : r_b;

    // Trial subtract on the N+1-bit shifted remainder. When it succeeds the
    // difference is below |b| and therefore fits in N bits.
    assign w_shift = {r_rem, r_dvd[N-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dsr});
    assign w_diff  = w_shift[N-1:0] - r_dsr;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = (b == '0) ? S_ZERO : S_PREP;
            S_PREP:   w_next = S_DIVIDE;
            S_DIVIDE: if (r_cnt == '0) w_next = S_FIXUP;
            S_FIXUP:  w_next = S_DONE;
            S_ZERO:   w_next = S_DONE;
            S_DONE:   if (w_xfer) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready = (r_state == S_IDLE);
        busy     = (r_state != S_IDLE);
    end

    // Datapath and result registers, sequenced by the current state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sm     <= 1'b0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_cnt    <= '0;
            r_quot   <= '0;
            r_remo   <= '0;
            r_dbz    <= 1'b0;
            r_ovalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a  <= a;
                        r_b  <= b;
                        r_sm <= w_sm_in;
                    end
                end
                S_PREP: begin
                    r_dvd    <= w_mag_a;
                    r_dsr    <= w_mag_b;
                    r_sign_q <= w_sa ^ w_sb;
                    r_sign_r <= w_sa;
                    r_rem    <= '0;
                    r_cnt    <= CW'(N - 1);
                end
                S_DIVIDE: begin
                    r_rem <= w_ge ? w_diff : w_shift[N-1:0];
                    r_dvd <= {r_dvd[N-2:0], w_ge};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIXUP: begin
                    r_quot   <= r_sign_q ? -r_dvd : r_dvd;
                    r_remo   <= r_sign_r ? -r_rem : r_rem;
                    r_ovalid <= 1'b1;
                end
                S_ZERO: begin
                    r_quot   <= '1;
                    r_remo   <= r_a;
                    r_dbz    <= 1'b1;
                    r_ovalid <= 1'b1;
                end
                S_DONE: begin
                    // quotient/remainder deliberately keep their last values
                    if (w_xfer) begin
                        r_ovalid <= 1'b0;
                        r_dbz    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid   = r_ovalid;
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, backpressure,
// mid-operation reset, random N=8 ops and a shuffled full N=4 sweep.
module tb_seq_divider;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       iv8, ir8, sm8, ov8, or8, dz8, bz8;
    logic [7:0] a8, b8, q8, r8;
    logic       iv4, ir4, sm4, ov4, or4, dz4, bz4;
    logic [3:0] a4, b4, q4, r4;

    int n_chk  = 0;
    int n_fail = 0;

    seq_divider #(.N(8), .SIGNED_EN(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .signed_mode(sm8), .out_valid(ov8), .out_ready(or8),
        .quotient(q8), .remainder(r8), .div_by_zero(dz8), .busy(bz8)
    );

    seq_divider #(.N(4), .SIGNED_EN(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .signed_mode(sm4), .out_valid(ov4), .out_ready(or4),
        .quotient(q4), .remainder(r4), .div_by_zero(dz4), .busy(bz4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on n-bit operands.
    task automatic ref_div(input int n, input logic [7:0] a, input logic [7:0] b, input bit sm,
                           output logic [7:0] q, output logic [7:0] r, output bit dz);
        int ai, bi, mask;
        mask = (1 << n) - 1;
        ai = int'(a) & mask;
        bi = int'(b) & mask;
        if (sm && ai >= (1 << (n - 1))) ai -= (1 << n);
        if (sm && bi >= (1 << (n - 1))) bi -= (1 << n);
        if (bi == 0) begin
            q  = 8'(mask);
            r  = 8'(int'(a) & mask);
            dz = 1'b1;
        end else begin
            q  = 8'((ai / bi) & mask);
            r  = 8'((ai % bi) & mask);
            dz = 1'b0;
        end
    endtask

    // One N=8 operation: accept, latency, result, optional stall, transfer.
    // With nq set, the next operands are presented and held during this op.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sm, input int bp,
                        input bit nq, input logic [7:0] na, input logic [7:0] nb, input string tag);
        logic [7:0] eq, er;
        bit         edz, irlow;
        int         t, e;
        ref_div(8, a, b, sm, eq, er, edz);
        a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1; or8 = (bp == 0);
        t = 0;
        while (!ir8 && t < 100) begin @(negedge clk); t++; end
        chk({tag, " ready"}, 32'(ir8), 32'd1);
        @(negedge clk);                       // accept edge (edge 0) has passed
        if (nq) begin
            a8 = na; b8 = nb;
        end else begin
            iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm;
        end
        e = 0; irlow = 1'b1;
        while (!ov8 && e < 40) begin
            if (ir8 || !bz8) irlow = 1'b0;
            @(negedge clk);
            e++;
        end
        chk({tag, " latency"}, e, (b == 8'd0) ? 32'd1 : 32'd10);
        chk({tag, " in_ready low"}, 32'(irlow & ~ir8), 32'd1);
        chk({tag, " quotient"}, q8, eq);
        chk({tag, " remainder"}, r8, er);
        chk({tag, " dbz"}, 32'(dz8), 32'(edz));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, 32'(ov8), 32'd1);
            chk({tag, " hold q"}, q8, eq);
            chk({tag, " hold r"}, r8, er);
            chk({tag, " hold dbz"}, 32'(dz8), 32'(edz));
            chk({tag, " hold in_ready"}, 32'(ir8), 32'd0);
        end
        or8 = 1'b1;
        @(negedge clk);                       // transfer edge has passed
        chk({tag, " post valid"}, 32'(ov8), 32'd0);
        chk({tag, " post dbz"}, 32'(dz8), 32'd0);
        chk({tag, " post in_ready"}, 32'(ir8), 32'd1);
        chk({tag, " post q kept"}, q8, eq);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit sm);
        logic [7:0] eq, er;
        bit         edz;
        int         t, e, bp;
        ref_div(4, {4'b0, a}, {4'b0, b}, sm, eq, er, edz);
        a4 = a; b4 = b; sm4 = sm; iv4 = 1'b1; or4 = 1'($urandom_range(0, 1));
        t = 0;
        while (!ir4 && t < 50) begin @(negedge clk); t++; end
        chk("n4 ready", 32'(ir4), 32'd1);
        @(negedge clk);
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = ~sm;
        e = 0;
        while (!ov4 && e < 40) begin @(negedge clk); e++; end
        chk("n4 latency", e, (b == 4'd0) ? 32'd1 : 32'd6);
        chk("n4 quotient", q4, eq);
        chk("n4 remainder", r4, er);
        chk("n4 dbz", 32'(dz4), 32'(edz));
        bp = $urandom_range(0, 2);
        if (or4 == 1'b0 || bp > 0) begin
            or4 = 1'b0;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk("n4 hold q", q4, eq);
                chk("n4 hold r", r4, er);
            end
        end
        or4 = 1'b1;
        @(negedge clk);
        chk("n4 post valid", 32'(ov4), 32'd0);
        chk("n4 post in_ready", 32'(ir4), 32'd1);
    endtask

    int ord[512];

    initial begin
        rst_n = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; sm8 = 0; or8 = 1;
        iv4 = 0; a4 = 0; b4 = 0; sm4 = 0; or4 = 1;
        repeat (3) @(negedge clk);
        chk("rst q", q8, 32'd0);
        chk("rst r", r8, 32'd0);
        chk("rst dbz", 32'(dz8), 32'd0);
        chk("rst valid", 32'(ov8), 32'd0);
        chk("rst in_ready", 32'(ir8), 32'd1);
        chk("rst busy", 32'(bz8), 32'd0);
        chk("rst4 valid", 32'(ov4), 32'd0);
        chk("rst4 in_ready", 32'(ir4), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run8(8'd100, 8'd7,  1'b0, 0, 1'b0, 8'd0, 8'd0, "u100_7");
        run8(8'hF9,  8'h02, 1'b1, 0, 1'b0, 8'd0, 8'd0, "s-7_2");
        run8(8'h07,  8'hFE, 1'b1, 0, 1'b0, 8'd0, 8'd0, "s7_-2");
        run8(8'h80,  8'hFF, 1'b1, 0, 1'b0, 8'd0, 8'd0, "s_ovf");
        run8(8'h80,  8'hFF, 1'b0, 0, 1'b0, 8'd0, 8'd0, "u80_ff");
        run8(8'd25,  8'd0,  1'b0, 0, 1'b0, 8'd0, 8'd0, "dz25");
        run8(8'hF0,  8'd0,  1'b1, 2, 1'b0, 8'd0, 8'd0, "dz_signed");
        run8(8'd200, 8'd9,  1'b0, 5, 1'b1, 8'd50, 8'd5, "bp200_9");
        run8(8'd50,  8'd5,  1'b0, 0, 1'b0, 8'd0, 8'd0, "queued50_5");

        // reset in the middle of DIVIDE (low at edge 4)
        a8 = 8'd77; b8 = 8'd3; sm8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);                       // edge 0: accept
        iv8 = 1'b0;
        repeat (3) @(negedge clk);            // edges 1..3
        rst_n = 1'b0;
        @(negedge clk);                       // edge 4
        rst_n = 1'b1;
        chk("midrst state", {ov8, ir8, bz8, dz8}, 32'b0100);
        chk("midrst q", q8, 32'd0);
        chk("midrst r", r8, 32'd0);
        repeat (12) @(negedge clk);
        chk("midrst no result", 32'(ov8), 32'd0);
        run8(8'd255, 8'd16, 1'b0, 0, 1'b0, 8'd0, 8'd0, "u255_16");

        for (int k = 0; k < 250; k++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            run8(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, 8'd0, 8'd0, "rand8");
        end

        for (int i = 0; i < 512; i++) ord[i] = i;
        for (int i = 0; i < 511; i++) begin
            int j, tmp;
            j = $urandom_range(i, 511);
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
        end
        for (int i = 0; i < 512; i++) begin
            int v;
            v = ord[i];
            run4(v[3:0], v[7:4], v[8]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring radix-2 integer divider. Successor to the combinational divider.
- Parametrised width; per-operation signed/unsigned mode; divide-by-zero and overflow handling.
- Valid/ready handshakes on both the operand and result sides, so it slots into pipelined datapaths in place of the single-cycle `/` and `%` logic.

Parameters:
- N, 8, operand/result width in bits (N >= 2).
- SIGNED_EN, 1, when 0 the signed_mode input is ignored and all operations are unsigned.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider can accept operands.
- a  input  N  dividend.
- b  input  N  divisor.
- signed_mode  input  1  1 = two's-complement operation (requires SIGNED_EN = 1).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  N  quotient.
- remainder  output  N  remainder.
- div_by_zero  output  1  set with result when b == 0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - quotient, remainder, div_by_zero and out_valid = 0; in_ready = 1; busy = 0.
  - Reset mid-operation aborts the operation silently; no result is produced.
- Handshakes:
  - Operand accept occurs on an edge with in_valid & in_ready.
  - Result transfer occurs on an edge with out_valid & out_ready.
  - in_ready is high only in IDLE. a, b and signed_mode are captured at accept and ignored afterwards.
- States:
  - IDLE: on accept, go to ZERO if b == 0, else PREP.
  - PREP (1 cycle): form magnitudes (negate a or b if signed and negative); record sign_q = sa ^ sb and sign_r = sa. Clear partial remainder and counter.
  - DIVIDE (exactly N cycles): each cycle, shift {rem, dividend} left by 1 and trial-subtract |b| (width N+1). If no borrow, keep the difference and set the quotient LSB to 1; else restore and set it to 0. The counter runs N-1 down to 0; leave on 0.
  - FIXUP (1 cycle): negate quotient if sign_q; negate remainder if sign_r. Load output registers and assert out_valid. Go to DONE.
  - ZERO (1 cycle): quotient = all ones, remainder = a (raw), div_by_zero = 1, out_valid = 1. Go to DONE.
  - DONE: hold all outputs stable while out_ready is low. On transfer, go to IDLE, clear out_valid and div_by_zero; quotient/remainder keep their last values.
- Latency: with accept at edge 0, out_valid rises after edge N+2 for normal ops and after edge 1 for divide-by-zero.
- No new operand is accepted in the DONE cycle. Minimum initiation interval is N+4 cycles with out_ready held high.
- Signed semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - a == b*q + r holds modulo 2^N.
  - Overflow (a = -2^(N-1), b = -1) yields quotient = -2^(N-1), remainder = 0, div_by_zero = 0. This falls out of the magnitude algorithm; no special case is needed.
- Unsigned mode matches a/b and a%b exactly for all b != 0.
- Simultaneous in_valid during a busy state is ignored: no accept, no corruption. The producer must hold in_valid until in_ready.

Test Plan:
- N=8 unsigned, a=100, b=7, out_ready=1 -> quotient=14, remainder=2, div_by_zero=0; out_valid rises after edge 10; in_ready low for edges 1..11.
- Signed: a=0xF9 (-7), b=2 -> quotient=0xFD (-3), remainder=0xFF (-1). Also a=7, b=0xFE -> quotient=0xFD, remainder=0x01.
- Signed overflow: a=0x80, b=0xFF -> quotient=0x80, remainder=0x00, div_by_zero=0. Unsigned a=0x80, b=0xFF -> quotient=0, remainder=0x80.
- Divide by zero: a=25, b=0 -> quotient=0xFF, remainder=25, div_by_zero=1; out_valid after edge 1.
- Backpressure: complete 200/9 (quotient=22, remainder=2) with out_ready low for 5 cycles -> outputs stable throughout. A second in_valid pulse (a=50, b=5) during DIVIDE/DONE is not accepted; when held until IDLE, it yields quotient=10, remainder=0.
- Reset mid-DIVIDE: rst_n low for 1 cycle at edge 4 -> state IDLE, out_valid=0, all outputs 0, in_ready=1 the following cycle. A subsequent 255/16 gives quotient=15, remainder=15. Randomised sweep of all N=4 operand pairs in both modes matches the reference model.
